// File: rtl/mcu_pkg.sv
// Shared definitions for the multicycle RV32I control unit: opcodes, ALU ops,
// FSM states and datapath source-select encodings.
package mcu_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9
    } alu_op_t;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_JALR   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        CLS_ADD = 2'd0,
        CLS_R   = 2'd1,
        CLS_I   = 2'd2,
        CLS_BR  = 2'd3
    } op_class_t;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MDR    = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;

    localparam logic [1:0] SRCB_RS2   = 2'd0;
    localparam logic [1:0] SRCB_IMM   = 2'd1;
    localparam logic [1:0] SRCB_FOUR  = 2'd2;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU-control decoder: maps the operation class and funct fields
// to an ALU op and flags encodings that are not legal RV32I.
module alu_decoder
    import mcu_pkg::*;
#(
    parameter int BRANCH_SET = 1
) (
    input  logic [1:0] op_class,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_op,
    output logic       illegal_fn
);

    always_comb begin
        alu_op     = ALU_ADD;
        illegal_fn = 1'b0;
        case (op_class)
            CLS_R, CLS_I: begin
                case (funct3)
                    3'b000: alu_op = (op_class == CLS_R && funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b111: alu_op = ALU_AND;
                    3'b110: alu_op = ALU_OR;
                    3'b100: alu_op = ALU_XOR;
                    3'b001: alu_op = ALU_SLL;
                    3'b101: alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b010: alu_op = ALU_SLT;
                    default: alu_op = ALU_SLTU;
                endcase
                if (op_class == CLS_R) begin
                    illegal_fn = !((funct7 == F7_ZERO) ||
                                   (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)));
                end else if (funct3 == 3'b001) begin
                    illegal_fn = (funct7 != F7_ZERO);
                end else if (funct3 == 3'b101) begin
                    illegal_fn = !(funct7 == F7_ZERO || funct7 == F7_ALT);
                end
            end
            CLS_BR: begin
                // funct3[2:1] selects the compare family; 01x has no branch encoding.
                case (funct3[2:1])
                    2'b00:   alu_op = ALU_SUB;
                    2'b10:   alu_op = ALU_SLT;
                    2'b11:   alu_op = ALU_SLTU;
                    default: illegal_fn = 1'b1;
                endcase
                if (BRANCH_SET == 0 && funct3[2]) begin
                    illegal_fn = 1'b1;
                end
            end
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore-style sequencer for the shared-memory multicycle RV32I datapath, with
// memory wait states, branch resolution and an illegal-instruction trap.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int ALUCTL_W      = 4,
    parameter int MEM_HANDSHAKE = 1,
    parameter int BRANCH_SET    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic                zero,
    input  logic                lt,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                adr_src,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic [1:0]          result_src,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUCTL_W-1:0] alu_control,
    output logic                illegal,
    output logic [3:0]          state_o
);

    state_t    state, state_next;
    logic      jalr_step, jalr_step_next;
    op_class_t op_class;
    logic [3:0] dec_op;
    logic       dec_illegal;
    logic [3:0] alu_sel;
    logic       mem_ok;
    logic       taken;

    assign mem_ok = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    always_comb begin
        case (state)
            S_EXEC_R: op_class = CLS_R;
            S_EXEC_I: op_class = CLS_I;
            S_BRANCH: op_class = CLS_BR;
            default:  op_class = CLS_ADD;
        endcase
    end

    alu_decoder #(
        .BRANCH_SET(BRANCH_SET)
    ) u_alu_decoder (
        .op_class   (op_class),
        .funct3     (funct3),
        .funct7     (funct7),
        .alu_op     (dec_op),
        .illegal_fn (dec_illegal)
    );

    always_comb begin
        case (funct3)
            3'b000:          taken = zero;
            3'b001:          taken = !zero;
            3'b100, 3'b110:  taken = lt;
            3'b101, 3'b111:  taken = !lt;
            default:         taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            jalr_step <= 1'b0;
        end else begin
            state     <= state_next;
            jalr_step <= jalr_step_next;
        end
    end

    // Outputs are forced to their idle values while rst_n is low so an
    // in-flight memory request drops immediately rather than showing FETCH.
    always_comb begin
        state_next     = state;
        jalr_step_next = 1'b0;
        pc_write       = 1'b0;
        adr_src        = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        ir_write       = 1'b0;
        reg_write      = 1'b0;
        result_src     = RES_ALUOUT;
        alu_src_a      = SRCA_PC;
        alu_src_b      = SRCB_RS2;
        alu_sel        = ALU_ADD;
        illegal        = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    pc_write  = mem_ok;
                    ir_write  = mem_ok;
                    if (mem_ok) state_next = S_DECODE;
                end
                S_DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    case (opcode)
                        OP_LOAD, OP_STORE: state_next = S_MEMADR;
                        OP_R:              state_next = S_EXEC_R;
                        OP_I:              state_next = S_EXEC_I;
                        OP_BRANCH:         state_next = S_BRANCH;
                        OP_JAL:            state_next = S_JAL;
                        OP_JALR:           state_next = S_JALR;
                        default:           state_next = S_TRAP;
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    if (funct3 != 3'b010)     state_next = S_TRAP;
                    else if (opcode == OP_LOAD) state_next = S_MEMRD;
                    else                      state_next = S_MEMWR;
                end
                S_MEMRD: begin
                    adr_src  = 1'b1;
                    mem_read = 1'b1;
                    if (mem_ok) state_next = S_MEMWB;
                end
                S_MEMWB: begin
                    result_src = RES_MDR;
                    reg_write  = 1'b1;
                    state_next = S_FETCH;
                end
                S_MEMWR: begin
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                    if (mem_ok) state_next = S_FETCH;
                end
                S_EXEC_R, S_EXEC_I: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = (state == S_EXEC_R) ? SRCB_RS2 : SRCB_IMM;
                    alu_sel    = dec_op;
                    state_next = dec_illegal ? S_TRAP : S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write  = 1'b1;
                    state_next = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_RS2;
                    alu_sel   = dec_op;
                    if (dec_illegal) begin
                        state_next = S_TRAP;
                    end else begin
                        pc_write   = taken;
                        state_next = S_FETCH;
                    end
                end
                S_JAL: begin
                    alu_src_a  = SRCA_OLDPC;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALU;
                    reg_write  = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_FETCH;
                end
                S_JALR: begin
                    if (!jalr_step) begin
                        alu_src_a = SRCA_RS1;
                        alu_src_b = SRCB_IMM;
                        if (funct3 != 3'b000) state_next = S_TRAP;
                        else                  jalr_step_next = 1'b1;
                    end else begin
                        alu_src_a  = SRCA_OLDPC;
                        alu_src_b  = SRCB_FOUR;
                        result_src = RES_ALU;
                        reg_write  = 1'b1;
                        pc_write   = 1'b1;
                        state_next = S_FETCH;
                    end
                end
                S_TRAP: illegal = 1'b1;
                default: state_next = S_TRAP;
            endcase
        end
    end

    assign alu_control = ALUCTL_W'(alu_sel);
    assign state_o     = state;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle RV32I control/ALU-control decoder. Sequences each instruction through a Moore-style FSM (fetch, decode, execute, memory, writeback).
- Adds a memory ready/valid wait-state handshake, branch resolution from the ALU zero flag, and an illegal-instruction flag.
- Sits between the instruction register and the shared-memory multicycle datapath.

Parameters:
- ALUCTL_W, 4, width of alu_control; values are 4'h0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, zero-extended for ALUCTL_W > 4.
- MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready ignored and treated as 1.
- BRANCH_SET, 1, 0 = beq/bne only; 1 = also blt/bge/bltu/bgeu. With 0, other funct3 values raise illegal.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- opcode, in, 7, IR[6:0].
- funct3, in, 3, IR[14:12].
- funct7, in, 7, IR[31:25].
- zero, in, 1, ALU zero flag.
- lt, in, 1, ALU less-than result (signed/unsigned per alu_control).
- mem_ready, in, 1, memory completes access this cycle.
- pc_write, out, 1, load PC.
- adr_src, out, 1, 0 = PC, 1 = ALUOut to memory address.
- mem_read, out, 1, memory read request.
- mem_write, out, 1, memory write request.
- ir_write, out, 1, latch instruction and oldPC.
- reg_write, out, 1, register-file write.
- result_src, out, 2, 0 = ALUOut, 1 = MDR, 2 = ALU result.
- alu_src_a, out, 2, 0 = PC, 1 = oldPC, 2 = rs1.
- alu_src_b, out, 2, 0 = rs2, 1 = imm, 2 = const 4.
- alu_control, out, ALUCTL_W, ALU operation.
- illegal, out, 1, sticky until next FETCH.
- state_o, out, 4, current state for debug.

Behaviour:
- Reset (rst_n low, async):
  - state = FETCH.
  - All strobes 0; result_src, alu_src_a and alu_src_b = 0; alu_control = ADD; illegal = 0.
  - Deassertion is synchronised by the datapath. The first cycle after reset is FETCH.
- All outputs are decoded from the registered state and instruction fields; no output depends combinationally on mem_ready.
  - Exception: in FETCH, pc_write and ir_write equal mem_ready.
- States (4-bit encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC_R 6, EXEC_I 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, TRAP 12.
- FETCH:
  - Outputs: adr_src 0, mem_read 1, alu_src_a 0, alu_src_b 2, ADD.
  - When mem_ready: ir_write 1, pc_write 1, go to DECODE. Otherwise hold FETCH with ir_write and pc_write at 0.
- DECODE:
  - Outputs: alu_src_a 1, alu_src_b 1, ADD (branch target to ALUOut).
  - Next state by opcode:
    - 0000011 or 0100011 → MEMADR.
    - 0110011 → EXEC_R.
    - 0010011 → EXEC_I.
    - 1100011 → BRANCH.
    - 1101111 → JAL.
    - 1100111 → JALR.
    - Any other opcode → TRAP.
- MEMADR:
  - Outputs: alu_src_a 2, alu_src_b 1, ADD.
  - Next: load → MEMRD; store → MEMWR.
  - Only funct3 = 010 is legal; anything else → TRAP.
- MEMRD: adr_src 1, mem_read 1. Go to MEMWB on mem_ready, else stay.
- MEMWB: result_src 1, reg_write 1 → FETCH.
- MEMWR: adr_src 1, mem_write 1, held until mem_ready → FETCH.
- EXEC_R:
  - Outputs: alu_src_a 2, alu_src_b 0.
  - ALU op from funct3 with funct7[5]: 000 ADD/SUB, 111 AND, 110 OR, 100 XOR, 001 SLL, 101 SRL/SRA, 010 SLT, 011 SLTU.
  - funct7 other than 0000000, or 0100000 on 000/101 → TRAP. Otherwise → ALUWB.
- EXEC_I:
  - Same mapping, but funct7[5] is used only for funct3 = 101; addi never subtracts.
  - slli/srli with funct7 ≠ 0000000 → TRAP; srai requires funct7 0100000.
  - → ALUWB.
- ALUWB: result_src 0, reg_write 1 → FETCH.
- BRANCH:
  - Outputs: alu_src_a 2, alu_src_b 0. Op is SUB for beq/bne, SLT for blt/bge, SLTU for bltu/bgeu.
  - result_src 0 (ALUOut target).
  - pc_write = taken, where taken is: zero (000), !zero (001), lt (100, 110), !lt (101, 111).
  - → FETCH.
- JAL:
  - Outputs: alu_src_a 1, alu_src_b 2, ADD (oldPC + 4); result_src 2 to the register file; reg_write 1.
  - pc_write 1 with PC taken from ALUOut (target computed in DECODE).
  - → FETCH.
- JALR:
  - Two cycles. Cycle 1: alu_src_a 2, alu_src_b 1, ADD.
  - Cycle 2 reuses the JAL outputs except pc_write takes the ALUOut target; track with an internal substep bit.
  - → FETCH. funct3 ≠ 000 → TRAP.
- TRAP: illegal 1, all strobes 0; held until rst_n. Only reset leaves TRAP.
- Reset asserted mid-access drops mem_read/mem_write in the same instant (async).

Decomposition:
- Package mcu_pkg holds: opcode constants, ALU op codes, state enum, and src-select encodings.
- Sub-module alu_decoder (combinational; opcode class, funct3, funct7 → alu_control, illegal_fn) is shared with the single-cycle core.

Test Plan:
- add x3 (0110011/000/0000000), mem_ready always 1:
  - states 0 → 1 → 6 → 8 → 0; alu_control 0 in EXEC_R; reg_write 1 only in ALUWB; 4 cycles total.
- lw (0000011/010), mem_ready low 2 cycles in MEMRD:
  - MEMRD held 3 cycles with mem_read 1, adr_src 1; then MEMWB with result_src 1, reg_write 1.
- sw (0100011/010):
  - MEMWR asserts mem_write until mem_ready; reg_write never 1.
- beq, then bne, with zero = 1:
  - beq: pc_write 1 in BRANCH. bne: pc_write 0. alu_control 1 in both.
- srai (0010011/101/0100000) → alu_control 7. slli with funct7 0100000 → TRAP, illegal 1, state 12 persists.
- rst_n pulsed low during MEMRD:
  - outputs immediately at reset values; after release the first state is FETCH.
